// File: rtl/e_mdu_ctrl_pkg.sv
// Shared MDU constants (mdOp encodings), FSM state type and op-decode helpers.
// Optional divider support is selected with the MDU_DIV_EN macro.
`ifndef E_MDU_CONST_V
`define E_MDU_CONST_V
`define MDU_MULT  3'd1
`define MDU_MULTU 3'd2
`define MDU_DIV   3'd3
`define MDU_DIVU  3'd4
`define MDU_MTHI  3'd5
`define MDU_MTLO  3'd6
`endif

package e_mdu_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    localparam logic [2:0] OP_MULT  = `MDU_MULT;
    localparam logic [2:0] OP_MULTU = `MDU_MULTU;
    localparam logic [2:0] OP_DIV   = `MDU_DIV;
    localparam logic [2:0] OP_DIVU  = `MDU_DIVU;
    localparam logic [2:0] OP_MTHI  = `MDU_MTHI;
    localparam logic [2:0] OP_MTLO  = `MDU_MTLO;

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that enter RUN; without the divider, DIV/DIVU decode as unknown.
    function automatic logic op_is_multi(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return (op == OP_MULT) || (op == OP_MULTU) || op_is_div(op);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit multiply / divide result generator for the MDU.
// Divider datapath exists only when MDU_DIV_EN is defined.
module e_mdu_arith
    import e_mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hiNext,
    output logic [31:0] loNext
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    logic [31:0] b_nz;
    logic        div_ovf;

    // Divide-by-zero results are discarded by the controller; b_nz only keeps X out.
    assign b_nz    = (b == 32'd0) ? 32'd1 : b;
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`endif

    always_comb begin
        hiNext = '0;
        loNext = '0;
        case (op)
            OP_MULT:  {hiNext, loNext} = prod_s;
            OP_MULTU: {hiNext, loNext} = prod_u;
`ifdef MDU_DIV_EN
            OP_DIV: begin
                if (div_ovf) begin
                    loNext = 32'h8000_0000;
                    hiNext = 32'd0;
                end else begin
                    loNext = $signed(a) / $signed(b_nz);
                    hiNext = $signed(a) % $signed(b_nz);
                end
            end
            OP_DIVU: begin
                loNext = a / b_nz;
                hiNext = a % b_nz;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: IDLE/RUN FSM, busy counter, operand latches, HI/LO.
// DIV/DIVU are accepted only when MDU_DIV_EN is defined.
module e_mdu_ctrl
    import e_mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output mdu_state_t  dbg_state_o
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

    mdu_state_t  state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic        commit_edge;
    logic        can_accept;
    logic        commit_ok;
    logic [3:0]  load_cnt;

    e_mdu_arith u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hiNext (hi_d),
        .loNext (lo_d)
    );

    assign commit_edge = (state_q == ST_RUN) && (cnt_q == 4'd0);
    assign can_accept  = (state_q == ST_IDLE) || commit_edge;
    assign commit_ok   = !(op_is_div(op_q) && (b_q == 32'd0));
    assign load_cnt    = op_is_div(mdOp) ? DIV_CNT : MULT_CNT;

    // Later assignments win: a move accepted on the commit edge overrides that half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            if (state_q == ST_RUN) begin
                if (cnt_q == 4'd0) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (commit_ok) begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                    end
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
            if (can_accept && start) begin
                if (op_is_multi(mdOp)) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                    cnt_q   <= load_cnt;
                    op_q    <= mdOp;
                    a_q     <= srcA;
                    b_q     <= srcB;
                end else if (mdOp == OP_MTHI) begin
                    hi_q <= srcA;
                end else if (mdOp == OP_MTLO) begin
                    lo_q <= srcA;
                end
            end
        end
    end

    assign busy        = busy_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: multiply/divide results, busy length, moves, ignored
// starts, commit-edge starts, unknown ops and asynchronous reset abort.
module tb_e_mdu_ctrl;
    import e_mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    mdu_state_t  dbg_state;

    int tests = 0;
    int fails = 0;

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mdOp        (mdOp),
        .srcA        (srcA),
        .srcB        (srcB),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .dbg_state_o (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one rising edge, then scramble operands to prove latching.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        mdOp  = 3'd0;
        srcA  = $urandom();
        srcB  = $urandom();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        int seen;

        reset_n = 1'b0;
        start   = 1'b0;
        mdOp    = 3'd0;
        srcA    = 32'd0;
        srcB    = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_state", {31'd0, dbg_state}, 32'd0);

        // First edge after release accepts MULT
        reset_n = 1'b1;
        drive(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        check("mult_busy_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        check("multu_busy_cycles", n, 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // MTLO during RUN is ignored
        drive(OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        check("run_busy", {31'd0, busy}, 32'd1);
        start = 1'b1;
        mdOp  = OP_MTLO;
        srcA  = 32'h1234;
        srcB  = 32'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("run_lo_held", lo, 32'hFFFF_FFFE);
        count_busy(n);
        check("run_rest_cycles", n, 32'd3);
        check("ign_mult_lo", lo, 32'd12);
        check("ign_mult_hi", hi, 32'd0);

        drive(OP_MTHI, 32'hAB, 32'd0);
        check("mthi_busy_edge", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("mthi_hi", hi, 32'hAB);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_lo", lo, 32'd12);

        // MULTU accepted on the commit edge of MULT 2*3
        drive(OP_MULT, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        drive(OP_MULTU, 32'd5, 32'd5);
        @(negedge clk);
        check("chain_first_lo", lo, 32'd6);
        check("chain_busy", {31'd0, busy}, 32'd1);
        count_busy(n);
        check("chain_rest_cycles", n, 32'd4);
        check("chain_lo", lo, 32'd25);
        check("chain_hi", hi, 32'd0);

        // MTHI on the commit edge overwrites the committed hi
        drive(OP_MULT, 32'd3, 32'd4);
        repeat (5) @(negedge clk);
        drive(OP_MTHI, 32'h55, 32'd0);
        @(negedge clk);
        check("cmt_mthi_busy", {31'd0, busy}, 32'd0);
        check("cmt_mthi_hi", hi, 32'h55);
        check("cmt_mthi_lo", lo, 32'd12);

        drive(3'd7, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        drive(3'd0, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        check("unk_busy", {31'd0, busy}, 32'd0);
        check("unk_hi", hi, 32'h55);
        check("unk_lo", lo, 32'd12);

`ifdef MDU_DIV_EN
        drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check("div_busy_cycles", n, 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        drive(OP_DIVU, 32'd7, 32'd2);
        count_busy(n);
        check("divu_busy_cycles", n, 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        drive(OP_MTHI, 32'h11, 32'd0);
        drive(OP_MTLO, 32'h22, 32'd0);
        drive(OP_DIVU, 32'd7, 32'd0);
        count_busy(n);
        check("div0_busy_cycles", n, 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        drive(OP_MTHI, 32'h55, 32'd0);
        drive(OP_DIV, 32'd100, 32'd7);
`else
        drive(OP_DIV, 32'd7, 32'd2);
        count_busy(n);
        check("nodiv_busy_cycles", n, 32'd0);
        check("nodiv_hi", hi, 32'h55);
        check("nodiv_lo", lo, 32'd12);

        drive(OP_MULT, 32'd100, 32'd7);
`endif
        // Abort the in-flight op with an asynchronous reset in its third cycle
        repeat (3) @(negedge clk);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy !== 1'b0) seen++;
        end
        check("post_abort_busy_seen", seen, 32'd0);
        check("post_abort_hi", hi, 32'd0);
        check("post_abort_lo", lo, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
